// File: rtl/cache_pkg.sv
// Shared cache-side types and default geometry for the line/burst adaptor.
package cache_pkg;

    localparam int unsigned DEF_S_OFFSET = 5;
    localparam int unsigned DEF_S_LINE   = 256;
    localparam int unsigned DEF_S_BURST  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port plus memory-side burst port of the adaptor.
interface cacheline_adaptor_if #(
    parameter int unsigned S_LINE  = cache_pkg::DEF_S_LINE,
    parameter int unsigned S_BURST = cache_pkg::DEF_S_BURST
);

    logic [31:0]        line_address_i;
    logic               line_read_i;
    logic               line_write_i;
    logic [S_LINE-1:0]  line_wdata_i;
    logic [S_LINE-1:0]  line_rdata_o;
    logic               line_resp_o;

    logic [31:0]        burst_address_o;
    logic               burst_read_o;
    logic               burst_write_o;
    logic [S_BURST-1:0] burst_wdata_o;
    logic [S_BURST-1:0] burst_rdata_i;
    logic               burst_resp_i;

    // Environment view: issues line requests and plays the memory.
    modport master (
        output line_address_i, line_read_i, line_write_i, line_wdata_i,
        output burst_rdata_i, burst_resp_i,
        input  line_rdata_o, line_resp_o,
        input  burst_address_o, burst_read_o, burst_write_o, burst_wdata_o
    );

    // Adaptor view.
    modport slave (
        input  line_address_i, line_read_i, line_write_i, line_wdata_i,
        input  burst_rdata_i, burst_resp_i,
        output line_rdata_o, line_resp_o,
        output burst_address_o, burst_read_o, burst_write_o, burst_wdata_o
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cache line request into a fixed-length burst on the memory bus,
// gathering read beats into a line or serialising a write-back line into beats.
module cacheline_adaptor
    import cache_pkg::*;
#(
    parameter int unsigned S_OFFSET = DEF_S_OFFSET,
    parameter int unsigned S_LINE   = DEF_S_LINE,
    parameter int unsigned S_BURST  = DEF_S_BURST
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.slave  bus
);

    localparam int unsigned BEATS = S_LINE / S_BURST;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0] ADDR_MASK = ~(32'((1 << S_OFFSET) - 1));

    adaptor_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [S_LINE-1:0]   r_line, w_line_nxt;
    logic [S_LINE-1:0]   r_rdata, w_rdata_nxt;
    logic [31:0]         r_addr, w_addr_nxt;
    logic [S_BURST-1:0]  r_wdata, w_wdata_nxt;
    logic                r_read, w_read_nxt;
    logic                r_write, w_write_nxt;
    logic                r_resp, w_resp_nxt;
    logic [S_LINE-1:0]   w_slot_fill;

    // Next-state and next-output computation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        w_rdata_nxt = r_rdata;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;

        w_slot_fill = r_line;
        w_slot_fill[int'(r_cnt) * S_BURST +: S_BURST] = bus.burst_rdata_i;

        case (r_state)
            IDLE: begin
                if (bus.line_write_i) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = bus.line_address_i & ADDR_MASK;
                    w_line_nxt  = bus.line_wdata_i;
                    w_wdata_nxt = bus.line_wdata_i[S_BURST-1:0];
                    w_cnt_nxt   = '0;
                end else if (bus.line_read_i) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = bus.line_address_i & ADDR_MASK;
                    w_cnt_nxt   = '0;
                end
            end
            READ: begin
                if (bus.burst_resp_i) begin
                    w_line_nxt = w_slot_fill;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = DONE;
                        w_rdata_nxt = w_slot_fill;
                    end
                end
            end
            WRITE: begin
                if (bus.burst_resp_i) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_wdata_nxt = r_line[(int'(r_cnt) + 1) * S_BURST +: S_BURST];
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_read_nxt  = (w_state_nxt == READ);
        w_write_nxt = (w_state_nxt == WRITE);
        w_resp_nxt  = (w_state_nxt == DONE);
    end

    // State and registered outputs; a reset mid-burst drops the partial line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
            r_rdata <= w_rdata_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    assign bus.line_rdata_o    = r_rdata;
    assign bus.line_resp_o     = r_resp;
    assign bus.burst_address_o = r_addr;
    assign bus.burst_read_o    = r_read;
    assign bus.burst_write_o   = r_write;
    assign bus.burst_wdata_o   = r_wdata;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomised bench for cacheline_adaptor: plays the cache and a memory with
// random response gaps, checking against a line/beat reference model.
module tb_cacheline_adaptor;
    import cache_pkg::*;

    localparam int unsigned BEATS = DEF_S_LINE / DEF_S_BURST;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks    = 0;
    int n_fails     = 0;
    int n_resp_seen = 0;
    int n_resp_exp  = 0;
    logic [255:0] last_line = '0;
    bit pat_q[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.line_resp_o === 1'b1) n_resp_seen++;
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] rnd256();
        return {rnd64(), rnd64(), rnd64(), rnd64()};
    endfunction

    // Memory response decision: forced pattern first, else random with bounded gaps.
    function automatic bit next_resp(input int waited);
        if (pat_q.size() > 0) return pat_q.pop_front();
        if (waited >= 6) return 1'b1;
        return ($urandom_range(0, 2) != 0);
    endfunction

    function automatic logic [2:0] ctl();
        return {bus.burst_read_o, bus.burst_write_o, bus.line_resp_o};
    endfunction

    task automatic run_read(input logic [31:0] addr, input bit hold,
                            input bit use_data, input logic [255:0] data);
        logic [31:0] exp_addr;
        logic [63:0] d;
        int k;
        int waited;
        bit r;
        exp_addr = addr & ~32'h1F;
        k = 0;
        waited = 0;
        @(negedge clk);
        check_eq("rd_idle_ctl", 256'(ctl()), 256'(3'b000));
        check_eq("rd_idle_hold", bus.line_rdata_o, last_line);
        bus.line_address_i = addr;
        bus.line_read_i    = 1'b1;
        bus.line_write_i   = 1'b0;
        @(posedge clk);
        while (k < int'(BEATS)) begin
            @(negedge clk);
            if (!hold) begin
                bus.line_read_i    = 1'b0;
                bus.line_address_i = $urandom;
            end
            check_eq("rd_busy_ctl", 256'(ctl()), 256'(3'b100));
            check_eq("rd_addr", 256'(bus.burst_address_o), 256'(exp_addr));
            r = next_resp(waited);
            d = use_data ? data[k*64 +: 64] : rnd64();
            bus.burst_resp_i  = r;
            bus.burst_rdata_i = d;
            if (r) begin
                last_line[k*64 +: 64] = d;
                k++;
                waited = 0;
            end else begin
                waited++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.burst_resp_i  = 1'b1;
        bus.burst_rdata_i = rnd64();
        check_eq("rd_done_ctl", 256'(ctl()), 256'(3'b001));
        check_eq("rd_line", bus.line_rdata_o, last_line);
        n_resp_exp++;
        if (!hold) bus.line_read_i = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] addr, input bit both,
                             input bit use_data, input logic [255:0] data);
        logic [31:0]  exp_addr;
        logic [255:0] line;
        int k;
        int waited;
        bit r;
        exp_addr = addr & ~32'h1F;
        line = use_data ? data : rnd256();
        k = 0;
        waited = 0;
        @(negedge clk);
        check_eq("wr_idle_ctl", 256'(ctl()), 256'(3'b000));
        bus.line_address_i = addr;
        bus.line_write_i   = 1'b1;
        bus.line_read_i    = both;
        bus.line_wdata_i   = line;
        @(posedge clk);
        while (k < int'(BEATS)) begin
            @(negedge clk);
            bus.line_write_i   = 1'b0;
            bus.line_read_i    = 1'b0;
            bus.line_wdata_i   = rnd256();
            bus.line_address_i = $urandom;
            check_eq("wr_busy_ctl", 256'(ctl()), 256'(3'b010));
            check_eq("wr_addr", 256'(bus.burst_address_o), 256'(exp_addr));
            check_eq("wr_beat", 256'(bus.burst_wdata_o), 256'(line[k*64 +: 64]));
            r = next_resp(waited);
            bus.burst_resp_i  = r;
            bus.burst_rdata_i = rnd64();
            if (r) begin
                k++;
                waited = 0;
            end else begin
                waited++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.burst_resp_i = 1'b0;
        check_eq("wr_done_ctl", 256'(ctl()), 256'(3'b001));
        check_eq("wr_rdata_keep", bus.line_rdata_o, last_line);
        n_resp_exp++;
    endtask

    initial begin
        logic [31:0] a;
        bus.line_address_i = '0;
        bus.line_read_i    = 1'b0;
        bus.line_write_i   = 1'b0;
        bus.line_wdata_i   = '0;
        bus.burst_rdata_i  = '0;
        bus.burst_resp_i   = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctl", 256'(ctl()), 256'(3'b000));
        check_eq("rst_addr", 256'(bus.burst_address_o), 256'(0));
        check_eq("rst_wdata", 256'(bus.burst_wdata_o), 256'(0));
        check_eq("rst_rdata", bus.line_rdata_o, 256'(0));
        rst = 1'b1;

        // Directed read, back-to-back beats.
        pat_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_read(32'h1234_567F, 1'b0, 1'b1,
                 {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        check_eq("rd_addr_const", 256'(bus.burst_address_o), 256'(32'h1234_5660));

        // Read with response gaps.
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_read($urandom, 1'b0, 1'b0, '0);

        // Directed write.
        run_write(32'h0000_ABCD, 1'b0, 1'b1,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Read and write requested together: write wins.
        run_write($urandom, 1'b1, 1'b0, '0);

        // Reset after two read beats.
        @(negedge clk);
        bus.line_address_i = $urandom;
        bus.line_read_i    = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.line_read_i   = 1'b0;
            bus.burst_resp_i  = 1'b1;
            bus.burst_rdata_i = rnd64();
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_ctl", 256'(ctl()), 256'(3'b000));
        check_eq("midrst_addr", 256'(bus.burst_address_o), 256'(0));
        check_eq("midrst_rdata", bus.line_rdata_o, 256'(0));
        rst = 1'b1;
        bus.burst_resp_i = 1'b0;
        last_line = '0;
        @(posedge clk);
        @(negedge clk);
        check_eq("postrst_ctl", 256'(ctl()), 256'(3'b000));
        run_read($urandom, 1'b0, 1'b0, '0);

        // Request held through DONE starts a second transaction.
        a = $urandom;
        run_read(a, 1'b1, 1'b0, '0);
        run_read(a, 1'b0, 1'b0, '0);

        // Random mix.
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 2))
                0:       run_read($urandom, 1'b0, 1'b0, '0);
                1:       run_write($urandom, 1'b0, 1'b0, '0);
                default: run_write($urandom, 1'b1, 1'b0, '0);
            endcase
        end

        repeat (3) @(negedge clk);
        check_eq("resp_pulses", 256'(n_resp_seen), 256'(n_resp_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
